// File: rtl/seg7_scan_if.sv
// Scanned 7-segment display bus: observed seg/an lines plus the recovered digit/frame results.
// master drives the display lines, slave is the decoder.
interface seg7_scan_if #(
  parameter int DIGITS = 4
);
  localparam int IDX_W = $clog2(DIGITS);

  logic                  en;
  logic [6:0]            seg;
  logic [DIGITS-1:0]     an;
  logic                  digit_vld;
  logic [IDX_W-1:0]      digit_idx;
  logic [3:0]            digit_val;
  logic                  digit_err;
  logic                  frame_vld;
  logic [4*DIGITS-1:0]   frame_bcd;
  logic                  frame_err;
  logic                  frame_timeout;

  modport master (
    output en, seg, an,
    input  digit_vld, digit_idx, digit_val, digit_err,
    input  frame_vld, frame_bcd, frame_err, frame_timeout
  );

  modport slave (
    input  en, seg, an,
    output digit_vld, digit_idx, digit_val, digit_err,
    output frame_vld, frame_bcd, frame_err, frame_timeout
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Recovers BCD digits and whole frames from a multiplexed 7-segment display bus.
// Define SEG7_ACTIVE_LOW_EN for common-anode displays (seg/an inverted at the sample register).
module seg7_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  seg7_scan_if.slave bus
);
  localparam int IDX_W = $clog2(DIGITS);
  localparam int TMO_W = $clog2(TIMEOUT);
  localparam int SW    = DIGITS + 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_COLLECT = 2'd2
  } state_t;

  // Returns {err, value}; blank maps to F, unknown patterns to E with err set.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h7E:   r = 5'h00;
      7'h30:   r = 5'h01;
      7'h6D:   r = 5'h02;
      7'h79:   r = 5'h03;
      7'h33:   r = 5'h04;
      7'h5B:   r = 5'h05;
      7'h5F:   r = 5'h06;
      7'h70:   r = 5'h07;
      7'h7F:   r = 5'h08;
      7'h7B:   r = 5'h09;
      7'h00:   r = 5'h0F;
      default: r = 5'h1E;
    endcase
    return r;
  endfunction

  function automatic logic is_onehot(input logic [DIGITS-1:0] v);
    return (v != {DIGITS{1'b0}}) && ((v & (v - DIGITS'(1'b1))) == {DIGITS{1'b0}});
  endfunction

  function automatic logic [IDX_W-1:0] onehot_index(input logic [DIGITS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = 0; i < DIGITS; i++) begin
      if (v[i]) begin
        idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  logic [SW-1:0]       sample_s;
  logic [SW-1:0]       s_q;
  logic [7:0]          cnt_q;
  logic [7:0]          cnt_d;
  state_t              state_q;
  logic [DIGITS-1:0]   mask_q;
  logic [DIGITS-1:0]   mask_d;
  logic                pend_q;
  logic [TMO_W-1:0]    tmo_q;
  logic [DIGITS-1:0]   an_s;
  logic [6:0]          seg_s;
  logic [4:0]          dec_s;
  logic [IDX_W-1:0]    cap_idx_s;
  logic                cap_s;
  logic                full_s;
  logic                tmo_hit_s;

  logic                digit_vld_q;
  logic [IDX_W-1:0]    digit_idx_q;
  logic [3:0]          digit_val_q;
  logic                digit_err_q;
  logic                frame_vld_q;
  logic [4*DIGITS-1:0] frame_bcd_q;
  logic                frame_err_q;
  logic                frame_timeout_q;

`ifdef SEG7_ACTIVE_LOW_EN
  assign sample_s = ~{bus.an, bus.seg};
`else
  assign sample_s = {bus.an, bus.seg};
`endif

  // Stability tracking, decode of the held sample and capture/timeout qualification.
  always_comb begin
    an_s      = s_q[SW-1:7];
    seg_s     = s_q[6:0];
    dec_s     = seg_decode(seg_s);
    cap_idx_s = onehot_index(an_s);
    mask_d    = mask_q | an_s;
    full_s    = &mask_d;
    // The first enabled edge (IDLE) starts a fresh dwell regardless of what was seen while disabled.
    if (!bus.en || (state_q == ST_IDLE)) begin
      cnt_d = 8'd0;
    end else if (sample_s != s_q) begin
      cnt_d = 8'd0;
    end else if (cnt_q == 8'hFF) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
    cap_s     = bus.en && (state_q != ST_IDLE) &&
                (cnt_q == 8'(STABLE_CYCLES - 1)) && is_onehot(an_s);
    tmo_hit_s = (state_q == ST_COLLECT) && !cap_s && (tmo_q == TMO_W'(TIMEOUT - 1));
  end

  // Sample register, frame-assembly FSM and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q             <= {SW{1'b0}};
      cnt_q           <= 8'd0;
      state_q         <= ST_IDLE;
      mask_q          <= {DIGITS{1'b0}};
      pend_q          <= 1'b0;
      tmo_q           <= {TMO_W{1'b0}};
      digit_vld_q     <= 1'b0;
      digit_idx_q     <= {IDX_W{1'b0}};
      digit_val_q     <= 4'd0;
      digit_err_q     <= 1'b0;
      frame_vld_q     <= 1'b0;
      frame_bcd_q     <= {(4*DIGITS){1'b0}};
      frame_err_q     <= 1'b0;
      frame_timeout_q <= 1'b0;
    end else begin
      s_q             <= sample_s;
      cnt_q           <= cnt_d;
      digit_vld_q     <= 1'b0;
      frame_vld_q     <= 1'b0;
      frame_timeout_q <= 1'b0;

      if (cap_s) begin
        digit_vld_q <= 1'b1;
        digit_idx_q <= cap_idx_s;
        digit_val_q <= dec_s[3:0];
        digit_err_q <= dec_s[4];
      end
      for (int i = 0; i < DIGITS; i++) begin
        if (cap_s && (cap_idx_s == IDX_W'(i))) begin
          frame_bcd_q[4*i +: 4] <= dec_s[3:0];
        end
      end

      if (!bus.en) begin
        state_q <= ST_IDLE;
        mask_q  <= {DIGITS{1'b0}};
        pend_q  <= 1'b0;
        tmo_q   <= {TMO_W{1'b0}};
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_SEARCH;
            mask_q  <= {DIGITS{1'b0}};
            pend_q  <= 1'b0;
            tmo_q   <= {TMO_W{1'b0}};
          end
          ST_SEARCH: begin
            if (cap_s) begin
              mask_q  <= an_s;
              pend_q  <= dec_s[4];
              tmo_q   <= {TMO_W{1'b0}};
              state_q <= ST_COLLECT;
            end
          end
          ST_COLLECT: begin
            if (cap_s) begin
              tmo_q <= {TMO_W{1'b0}};
              if (full_s) begin
                frame_vld_q <= 1'b1;
                frame_err_q <= pend_q | dec_s[4];
                mask_q      <= {DIGITS{1'b0}};
                pend_q      <= 1'b0;
                state_q     <= ST_SEARCH;
              end else begin
                mask_q <= mask_d;
                pend_q <= pend_q | dec_s[4];
              end
            end else if (tmo_hit_s) begin
              frame_timeout_q <= 1'b1;
              mask_q          <= {DIGITS{1'b0}};
              pend_q          <= 1'b0;
              tmo_q           <= {TMO_W{1'b0}};
              state_q         <= ST_SEARCH;
            end else begin
              tmo_q <= tmo_q + TMO_W'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
            mask_q  <= {DIGITS{1'b0}};
            pend_q  <= 1'b0;
            tmo_q   <= {TMO_W{1'b0}};
          end
        endcase
      end
    end
  end

  assign bus.digit_vld     = digit_vld_q;
  assign bus.digit_idx     = digit_idx_q;
  assign bus.digit_val     = digit_val_q;
  assign bus.digit_err     = digit_err_q;
  assign bus.frame_vld     = frame_vld_q;
  assign bus.frame_bcd     = frame_bcd_q;
  assign bus.frame_err     = frame_err_q;
  assign bus.frame_timeout = frame_timeout_q;
endmodule
